// File: rtl/rf_regfile.sv
// rf_regfile -- general-purpose register file with a hardware stack pointer.
//
// Holds NUM_REGS 8-bit registers. There is one synchronous write port and two
// combinational read ports. The last register, r[NUM_REGS-1], is the stack
// pointer. It can also be incremented or decremented for push/pop sequencing.
//
// Ports:
//   clk            system clock; all state updates on the rising edge
//   rst            synchronous, active-high reset
//   rf_in          write data from the register-file input mux
//   rf_write_en    write strobe; rf_in -> r[rf_write_sel]
//   rf_write_sel   write destination index
//   rf_read_sel_a  read port A index
//   rf_read_sel_b  read port B index
//   sp_inc         increment stack pointer this cycle
//   sp_dec         decrement stack pointer this cycle
//   rf_out_a       r[rf_read_sel_a] (combinational, no write bypass)
//   rf_out_b       r[rf_read_sel_b] (combinational, no write bypass)
//   r0             r[0], fed back to the input mux
//   sp             r[NUM_REGS-1]
module rf_regfile #(
  parameter int         NUM_REGS = 8,
  parameter int         SEL_W    = $clog2(NUM_REGS),
  parameter logic [7:0] SP_RESET = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rf_in,
  input  logic             rf_write_en,
  input  logic [SEL_W-1:0] rf_write_sel,
  input  logic [SEL_W-1:0] rf_read_sel_a,
  input  logic [SEL_W-1:0] rf_read_sel_b,
  input  logic             sp_inc,
  input  logic             sp_dec,
  output logic [7:0]       rf_out_a,
  output logic [7:0]       rf_out_b,
  output logic [7:0]       r0,
  output logic [7:0]       sp
);

  localparam logic [SEL_W-1:0] SP_IDX = SEL_W'(NUM_REGS - 1);

  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];

  // An explicit write to the SP index overrides inc/dec. Otherwise inc and
  // dec cancel each other out. A write to any other index does not block
  // the SP update.
  always_comb begin
    regs_d = regs_q;
    if (rf_write_en) begin
      regs_d[rf_write_sel] = rf_in;
    end
    if (!(rf_write_en && (rf_write_sel == SP_IDX))) begin
      if (sp_inc && !sp_dec) begin
        regs_d[SP_IDX] = regs_q[SP_IDX] + 8'd1;
      end else if (sp_dec && !sp_inc) begin
        regs_d[SP_IDX] = regs_q[SP_IDX] - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[SEL_W'(i)] <= (i == NUM_REGS - 1) ? SP_RESET : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rf_out_a = regs_q[rf_read_sel_a];
  assign rf_out_b = regs_q[rf_read_sel_b];
  assign r0       = regs_q[0];
  assign sp       = regs_q[SP_IDX];

endmodule

// File: doc/rf_regfile.md
Name: rf_regfile

Overview:
- Register file that consumes the 8-bit write data produced by the register-file input mux (rf_in) and supplies operands to the ALU, memory unit and the mux's r0 input.
- Holds NUM_REGS general registers, clocked, with one write port and two combinational read ports.
- The last register is the stack pointer and also has hardware increment/decrement for push/pop sequencing.

Parameters:
- NUM_REGS, 8, number of registers; must be a power of two, at least 2.
- SEL_W, $clog2(NUM_REGS), width of the register select fields.
- SP_RESET, 8'hFF, reset value of the stack-pointer register r[NUM_REGS-1].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rf_in  input  8  write data from the register-file input mux.
- rf_write_en  input  1  write strobe; when 1, rf_in is written to r[rf_write_sel].
- rf_write_sel  input  SEL_W  write destination index.
- rf_read_sel_a  input  SEL_W  read port A index.
- rf_read_sel_b  input  SEL_W  read port B index.
- sp_inc  input  1  increment stack pointer by 1 this cycle.
- sp_dec  input  1  decrement stack pointer by 1 this cycle.
- rf_out_a  output  8  contents of r[rf_read_sel_a].
- rf_out_b  output  8  contents of r[rf_read_sel_b].
- r0  output  8  contents of r[0]; fed back to the input mux.
- sp  output  8  contents of r[NUM_REGS-1].

Behaviour:
- Reset: on a rising edge with rst=1, r[0..NUM_REGS-2] become 8'h00 and r[NUM_REGS-1] becomes SP_RESET.
  - rst has priority over write, sp_inc and sp_dec.
  - Outputs reflect the reset values combinationally from the next cycle: rf_out_a/b = 0 (or SP_RESET if they select the SP), r0 = 0, sp = SP_RESET.
- Reads are combinational from the register array.
  - Latency: 0 cycles from select change to output.
  - Latency: 1 cycle from write to visible data.
  - No write-to-read bypass: in the cycle of a write, reads of the same index return the old value. The new value appears after the edge.
- Write: at a rising edge with rf_write_en=1, r[rf_write_sel] <= rf_in. All other registers hold.
- Stack pointer update at the rising edge, evaluated in this priority order:
  1. rf_write_en=1 and rf_write_sel=NUM_REGS-1: explicit write wins; sp_inc/sp_dec are ignored.
  2. sp_inc=1 and sp_dec=1: SP unchanged.
  3. sp_inc=1 only: SP <= SP+1, mod 256 (8'hFF wraps to 8'h00).
  4. sp_dec=1 only: SP <= SP-1, mod 256 (8'h00 wraps to 8'hFF).
  5. Otherwise SP holds.
- sp_inc/sp_dec together with a write to any other index: both updates take effect in the same cycle.
- Out-of-range selects cannot occur, because NUM_REGS is a power of two and SEL_W = $clog2(NUM_REGS).
- Reset mid-operation: any pending write or SP update in a reset cycle is discarded. There is no other internal state.
- No X propagation: every register is defined after the first reset edge.
- Arithmetic is 8-bit unsigned modular. No flags are produced.

Test Plan:
- Reset: assert rst for 1 cycle, then release; read all indices on A and B -> r0..r6 = 8'h00, r7 = sp = 8'hFF, r0 output = 8'h00.
- Write/read and no bypass: write rf_in=8'hA5 to r3 with read_sel_a=3 in the same cycle -> rf_out_a = 8'h00 that cycle and 8'hA5 the next; write 8'h3C to r0 -> r0 output = 8'h3C one cycle later, other registers unchanged.
- SP wrap: after reset assert sp_inc for 1 cycle -> sp = 8'h00; assert sp_dec for 2 cycles -> sp = 8'hFE.
- SP conflicts:
  - sp_inc and sp_dec together -> sp holds.
  - Write 8'h40 to r7 together with sp_inc -> sp = 8'h40, not 8'h41.
  - Write 8'h11 to r2 together with sp_dec from 8'h40 -> r2 = 8'h11 and sp = 8'h3F.
- Dual read: load r1=8'h12 and r6=8'h34; set sel_a=1, sel_b=6, then swap the selects -> outputs follow the selects combinationally in the same cycle.
- Reset mid-operation: rst=1 together with rf_write_en (r5 <= 8'h77) and sp_inc -> r5 = 8'h00 and sp = 8'hFF after the edge.
